// File: rtl/register_file.sv
// register_file: 2-read/1-write register file with hardwired zero entry, debug read port and optional write-to-read forwarding
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32,
   parameter int BYPASS     = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] readReg1,
   input  logic [ADDR_WIDTH-1:0] readReg2,
   input  logic [ADDR_WIDTH-1:0] writeReg,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  regWrite,
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2,
   input  logic [ADDR_WIDTH-1:0] dbgReg,
   output logic [DATA_WIDTH-1:0] dbgData
);
   logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];
   logic we, fwd1, fwd2;
   function automatic logic [DATA_WIDTH-1:0] stored(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] r [1:NUM_REGS-1]);
      return (a != '0 && int'(a) < NUM_REGS) ? r[a] : '0;
   endfunction
   assign we = regWrite && writeReg != '0 && int'(writeReg) < NUM_REGS;
   always_comb begin
      for (int i = 1; i < NUM_REGS; i++) regs_d[i] = (we && int'(writeReg) == i) ? writeData : regs_q[i];
   end
   always_ff @(posedge clk) begin
      if (reset) regs_q <= '{default: '0};
      else regs_q <= regs_d;
   end
   // Forwarding never touches the debug port, so it always shows committed state.
   assign fwd1 = BYPASS != 0 && regWrite && !reset && writeReg != '0 && readReg1 == writeReg;
   assign fwd2 = BYPASS != 0 && regWrite && !reset && writeReg != '0 && readReg2 == writeReg;
   assign readData1 = fwd1 ? writeData : stored(readReg1, regs_q);
   assign readData2 = fwd2 ? writeData : stored(readReg2, regs_q);
   assign dbgData   = stored(dbgReg, regs_q);
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed checks of two register_file instances against an array model
module tb_register_file;
   logic clk = 0, rst = 0, rw = 0;
   logic [4:0] rr1 = 0, rr2 = 0, wr = 0, dbg = 0;
   logic [31:0] wd = 0;
   logic [31:0] a1, a2, ad, b1, b2, bd;
   logic [31:0] m0 [32], m1 [32];
   int pass = 0, total = 0;
   always #5 clk = ~clk;
   register_file dut0 (.clk(clk), .reset(rst), .readReg1(rr1), .readReg2(rr2), .writeReg(wr),
      .writeData(wd), .regWrite(rw), .readData1(a1), .readData2(a2), .dbgReg(dbg), .dbgData(ad));
   register_file #(.NUM_REGS(20), .BYPASS(1)) dut1 (.clk(clk), .reset(rst), .readReg1(rr1),
      .readReg2(rr2), .writeReg(wr), .writeData(wd), .regWrite(rw), .readData1(b1),
      .readData2(b2), .dbgReg(dbg), .dbgData(bd));
   // Reference: instance 0 has 32 plain registers, instance 1 has 20 registers with forwarding.
   function automatic logic [31:0] exp_rd(input int inst, input logic [4:0] a, input bit port);
      int n = inst ? 20 : 32;
      if (port && inst == 1 && rw && !rst && wr != 0 && wr == a) return wd;
      if (a == 0 || int'(a) >= n) return 0;
      return inst ? m1[a] : m0[a];
   endfunction
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 32; i++) begin
         if (rst) begin m0[i] = 0; m1[i] = 0; end
      end
      if (!rst && rw && wr != 0) begin
         m0[wr] = wd;
         if (wr < 20) m1[wr] = wd;
      end
      #1;
   endtask
   task automatic write(input logic [4:0] r, input logic [31:0] d);
      rw = 1; wr = r; wd = d;
      tick();
      rw = 0;
   endtask
   task automatic test_reset();
      rst = 1; rw = 0;
      tick();
      rst = 0;
      for (int i = 0; i < 32; i++) begin
         rr1 = 5'(i); rr2 = 5'(31 - i); dbg = 5'(i); #1;
         total += 6;
         if (a1 !== 0) $display("FAIL reset_rd1 idx %0d got %h want 0", i, a1); else pass++;
         if (a2 !== 0) $display("FAIL reset_rd2 idx %0d got %h want 0", 31 - i, a2); else pass++;
         if (ad !== 0) $display("FAIL reset_dbg idx %0d got %h want 0", i, ad); else pass++;
         if (b1 !== 0) $display("FAIL reset_b_rd1 idx %0d got %h want 0", i, b1); else pass++;
         if (b2 !== 0) $display("FAIL reset_b_rd2 idx %0d got %h want 0", 31 - i, b2); else pass++;
         if (bd !== 0) $display("FAIL reset_b_dbg idx %0d got %h want 0", i, bd); else pass++;
      end
   endtask
   task automatic test_basic();
      write(8, 32'hAABBCCDD);
      write(9, 32'h00112233);
      rr1 = 8; rr2 = 9; #1;
      total += 5;
      if (a1 !== 32'hAABBCCDD) $display("FAIL basic_rd1 got %h want aabbccdd", a1); else pass++;
      if (a2 !== 32'h00112233) $display("FAIL basic_rd2 got %h want 00112233", a2); else pass++;
      if (a1 + a2 !== 32'hAACCEF10) $display("FAIL basic_sum got %h want aaccef10", a1 + a2); else pass++;
      if (b1 !== 32'hAABBCCDD) $display("FAIL basic_b_rd1 got %h want aabbccdd", b1); else pass++;
      rr2 = 8; #1;
      if (a2 !== a1 || a2 !== 32'hAABBCCDD) $display("FAIL basic_same_idx got %h want aabbccdd", a2); else pass++;
   endtask
   task automatic test_r0();
      write(0, 32'hFFFFFFFF);
      rr1 = 0; rr2 = 0; dbg = 0; #1;
      total += 3;
      if (a1 !== 0) $display("FAIL r0_rd1 got %h want 0", a1); else pass++;
      if (a2 !== 0) $display("FAIL r0_rd2 got %h want 0", a2); else pass++;
      if (ad !== 0) $display("FAIL r0_dbg got %h want 0", ad); else pass++;
      for (int i = 0; i < 32; i++) begin
         dbg = 5'(i); #1;
         total += 2;
         if (ad !== exp_rd(0, dbg, 0)) $display("FAIL r0_sweep idx %0d got %h want %h", i, ad, exp_rd(0, dbg, 0)); else pass++;
         if (bd !== exp_rd(1, dbg, 0)) $display("FAIL r0_b_sweep idx %0d got %h want %h", i, bd, exp_rd(1, dbg, 0)); else pass++;
      end
   endtask
   task automatic test_same_cycle();
      write(5, 32'h11111111);
      rr1 = 5; dbg = 5; rw = 1; wr = 5; wd = 32'h22222222; #1;
      total += 3;
      if (a1 !== 32'h11111111) $display("FAIL same_pre got %h want 11111111", a1); else pass++;
      if (b1 !== 32'h22222222) $display("FAIL same_bypass_pre got %h want 22222222", b1); else pass++;
      if (bd !== 32'h11111111) $display("FAIL same_bypass_dbg got %h want 11111111", bd); else pass++;
      tick();
      rw = 0; #1;
      total += 2;
      if (a1 !== 32'h22222222) $display("FAIL same_post got %h want 22222222", a1); else pass++;
      if (b1 !== 32'h22222222) $display("FAIL same_bypass_post got %h want 22222222", b1); else pass++;
   endtask
   task automatic test_reset_vs_write();
      write(3, 32'hDEADBEEF);
      rr1 = 3; #1;
      total++;
      if (a1 !== 32'hDEADBEEF) $display("FAIL rvw_pre got %h want deadbeef", a1); else pass++;
      rst = 1; rw = 1; wr = 3; wd = 32'h12345678; #1;
      total++;
      if (a1 !== 32'hDEADBEEF) $display("FAIL rvw_hold got %h want deadbeef", a1); else pass++;
      tick();
      rst = 0; rw = 0; #1;
      total += 2;
      if (a1 !== 0) $display("FAIL rvw_post got %h want 0", a1); else pass++;
      if (b1 !== 0) $display("FAIL rvw_b_post got %h want 0", b1); else pass++;
   endtask
   task automatic test_we_off();
      rw = 0; wr = 7; wd = 32'hCAFEF00D; rr2 = 7; dbg = 7;
      repeat (3) tick();
      total += 2;
      if (a2 !== 0) $display("FAIL we_off_rd2 got %h want 0", a2); else pass++;
      if (ad !== 0) $display("FAIL we_off_dbg got %h want 0", ad); else pass++;
   endtask
   task automatic test_out_of_range();
      write(25, 32'h5A5A5A5A);
      rr1 = 25; #1;
      total += 2;
      if (a1 !== 32'h5A5A5A5A) $display("FAIL oor_full got %h want 5a5a5a5a", a1); else pass++;
      if (b1 !== 0) $display("FAIL oor_small got %h want 0", b1); else pass++;
   endtask
   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst = $urandom_range(0, 24) == 0;
         rw = 1'($urandom);
         wr = 5'($urandom);
         wd = $urandom;
         rr1 = $urandom_range(0, 1) ? wr : 5'($urandom);
         rr2 = $urandom_range(0, 3) == 0 ? wr : 5'($urandom);
         dbg = $urandom_range(0, 1) ? wr : 5'($urandom);
         #1;
         total += 6;
         if (a1 !== exp_rd(0, rr1, 1)) $display("FAIL rand_rd1 n=%0d got %h want %h", n, a1, exp_rd(0, rr1, 1)); else pass++;
         if (a2 !== exp_rd(0, rr2, 1)) $display("FAIL rand_rd2 n=%0d got %h want %h", n, a2, exp_rd(0, rr2, 1)); else pass++;
         if (ad !== exp_rd(0, dbg, 0)) $display("FAIL rand_dbg n=%0d got %h want %h", n, ad, exp_rd(0, dbg, 0)); else pass++;
         if (b1 !== exp_rd(1, rr1, 1)) $display("FAIL rand_b_rd1 n=%0d got %h want %h", n, b1, exp_rd(1, rr1, 1)); else pass++;
         if (b2 !== exp_rd(1, rr2, 1)) $display("FAIL rand_b_rd2 n=%0d got %h want %h", n, b2, exp_rd(1, rr2, 1)); else pass++;
         if (bd !== exp_rd(1, dbg, 0)) $display("FAIL rand_b_dbg n=%0d got %h want %h", n, bd, exp_rd(1, dbg, 0)); else pass++;
         tick();
      end
      rst = 0; rw = 0;
   endtask
   initial begin
      for (int i = 0; i < 32; i++) begin m0[i] = 0; m1[i] = 0; end
      @(negedge clk);
      test_reset();
      test_basic();
      test_r0();
      test_same_cycle();
      test_reset_vs_write();
      test_we_off();
      test_out_of_range();
      test_random();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
